// File: rtl/clock_pkg.sv
// Shared display constants for the clock subsystem: seven-segment patterns
// (active-low {g,f,e,d,c,b,a}) and scan digit positions.
package clock_pkg;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [2:0] DIG_SEC_ONES = 3'd0;
   localparam logic [2:0] DIG_SEC_TENS = 3'd1;
   localparam logic [2:0] DIG_MIN_ONES = 3'd2;
   localparam logic [2:0] DIG_MIN_TENS = 3'd3;
   localparam logic [2:0] DIG_HR_ONES  = 3'd4;
   localparam logic [2:0] DIG_HR_TENS  = 3'd5;
   localparam logic [2:0] DIG_LAST     = DIG_HR_TENS;

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      return (v <= 4'd9) ? SEG_DIGIT[v] : SEG_BLANK;
   endfunction

endpackage

// File: rtl/bin60_to_bcd.sv
// Splits a 0..59 binary field into BCD tens/ones; values above 59 are flagged.
module bin60_to_bcd (
   input  logic [5:0] bin_i,
   output logic [3:0] tens_o,
   output logic [3:0] ones_o,
   output logic       invalid_o
);

   always_comb begin
      tens_o = 4'd0;
      if      (bin_i >= 6'd50) tens_o = 4'd5;
      else if (bin_i >= 6'd40) tens_o = 4'd4;
      else if (bin_i >= 6'd30) tens_o = 4'd3;
      else if (bin_i >= 6'd20) tens_o = 4'd2;
      else if (bin_i >= 6'd10) tens_o = 4'd1;
      // the remainder is below 16, so 4-bit modular arithmetic is exact
      ones_o    = bin_i[3:0] - 4'(tens_o * 4'd10);
      invalid_o = (bin_i > 6'd59);
   end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment scanner (HH:MM:SS) with per-frame
// snapshot of the time source, blanking, dashes for bad fields and buzzer blink.
module clock_display_scan
   import clock_pkg::*;
#(
   parameter int SCAN_DIV     = 4,
   parameter int BLINK_FRAMES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] hr,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   input  logic [5:0] timer_min_left,
   input  logic [5:0] timer_sec_left,
   input  logic       AM_PM,
   input  logic       AM_mode,
   input  logic       disp_sel,
   input  logic       timer_buzzer,
   input  logic       alarm_buzzer,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   logic [SW-1:0] scan_cnt_q;
   logic [2:0]    digit_q;
   logic [FW-1:0] frame_cnt_q;
   logic          blink_ph_q;
   logic [5:0]    snap_hr_q, snap_min_q, snap_sec_q;
   logic          snap_pm_q, snap_12h_q, snap_sel_q;
   // One-cycle delayed copy of the scan position: the digit being shown
   // always reads the snapshot that was captured at its own frame start.
   logic          vld_p_q;
   logic [2:0]    digit_p_q;
   logic          blink_p_q;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [5:0]    an_q, an_d;

   logic [3:0] hr_t, hr_o, mn_t, mn_o, sc_t, sc_o;
   logic       hr_inv, mn_inv, sc_inv;

   bin60_to_bcd u_hr  (.bin_i(snap_hr_q),  .tens_o(hr_t), .ones_o(hr_o), .invalid_o(hr_inv));
   bin60_to_bcd u_min (.bin_i(snap_min_q), .tens_o(mn_t), .ones_o(mn_o), .invalid_o(mn_inv));
   bin60_to_bcd u_sec (.bin_i(snap_sec_q), .tens_o(sc_t), .ones_o(sc_o), .invalid_o(sc_inv));

   logic [3:0] f_tens, f_ones;
   logic       f_inv, f_hour;

   always_comb begin
      f_tens = sc_t;
      f_ones = sc_o;
      f_inv  = sc_inv;
      f_hour = 1'b0;
      case (digit_p_q)
         DIG_MIN_ONES, DIG_MIN_TENS: begin
            f_tens = mn_t;
            f_ones = mn_o;
            f_inv  = mn_inv;
         end
         DIG_HR_ONES, DIG_HR_TENS: begin
            f_tens = hr_t;
            f_ones = hr_o;
            f_inv  = hr_inv;
            f_hour = 1'b1;
         end
         default: ;
      endcase

      if (!vld_p_q)                                        seg_d = SEG_BLANK;
      else if (f_hour && snap_sel_q)                       seg_d = SEG_BLANK;
      else if (f_inv)                                      seg_d = SEG_DASH;
      else if (digit_p_q == DIG_HR_TENS && f_tens == 4'd0 && snap_12h_q)
                                                           seg_d = SEG_BLANK;
      else                                                 seg_d = seg_of(digit_p_q[0] ? f_tens : f_ones);

      an_d = 6'h3F;
      if (vld_p_q && !((timer_buzzer || alarm_buzzer) && blink_p_q))
         an_d = ~(6'd1 << digit_p_q);

      dp_d = 1'b1;
      if (vld_p_q) begin
         if (digit_p_q == DIG_MIN_ONES || digit_p_q == DIG_HR_ONES) dp_d = 1'b0;
         else if (digit_p_q == DIG_SEC_ONES)                        dp_d = ~(snap_12h_q & snap_pm_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt_q  <= '0;
         digit_q     <= '0;
         frame_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         snap_hr_q   <= '0;
         snap_min_q  <= '0;
         snap_sec_q  <= '0;
         snap_pm_q   <= 1'b0;
         snap_12h_q  <= 1'b0;
         snap_sel_q  <= 1'b0;
         vld_p_q     <= 1'b0;
         digit_p_q   <= '0;
         blink_p_q   <= 1'b0;
         seg_q       <= SEG_BLANK;
         dp_q        <= 1'b1;
         an_q        <= 6'h3F;
      end else begin
         vld_p_q   <= 1'b1;
         digit_p_q <= digit_q;
         blink_p_q <= blink_ph_q;

         if (digit_q == DIG_SEC_ONES && scan_cnt_q == '0) begin
            snap_hr_q  <= disp_sel ? 6'd0 : hr;
            snap_min_q <= disp_sel ? timer_min_left : min;
            snap_sec_q <= disp_sel ? timer_sec_left : sec;
            snap_pm_q  <= AM_PM;
            snap_12h_q <= AM_mode;
            snap_sel_q <= disp_sel;
         end

         if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            if (digit_q == DIG_LAST) begin
               digit_q <= '0;
               if (frame_cnt_q == FRAME_LAST) begin
                  frame_cnt_q <= '0;
                  blink_ph_q  <= ~blink_ph_q;
               end else begin
                  frame_cnt_q <= frame_cnt_q + 1'b1;
               end
            end else begin
               digit_q <= digit_q + 3'd1;
            end
         end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
         end

         seg_q <= seg_d;
         dp_q  <= dp_d;
         an_q  <= an_d;
      end
   end

   assign seg = seg_q;
   assign dp  = dp_q;
   assign an  = an_q;

endmodule
